spi_register_bridge: RTL and testbench
======================================

Name: spi_register_bridge

Overview:
- Sits directly downstream of the SPI secondary shift stage. Consumes its per-word `word_ready` pulse and `data_word_received`, and drives `data_word_to_send` back to it.
- Decodes each chip-select frame as a command word followed by burst data words.
- Maintains an internal register file with auto-incrementing address. Emits a write strobe per written word for the motion/stepper logic that consumes configuration.

Parameters:
- WORD_BITS, 8, SPI word width; must equal the SPI secondary's WORD_BITS.
- ADDR_BITS, 4, register address width; must be <= WORD_BITS-1.
- NUM_REGS, 16, number of registers; must be <= 2**ADDR_BITS and >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- neg_enable  input  1  SPI ~chip-select, raw pin; low = frame active.
- word_ready  input  1  one-clk pulse from SPI secondary: a full word was received.
- data_word_received  input  WORD_BITS  word valid in the cycle word_ready=1.
- data_word_to_send  output  WORD_BITS  word the SPI secondary shifts out next.
- reg_write_valid  output  1  one-clk write strobe.
- reg_write_addr  output  ADDR_BITS  address of that write.
- reg_write_data  output  WORD_BITS  data of that write.
- status_count  output  WORD_BITS  number of data words written since reset, wrapping.

Behaviour:
- Reset:
  - state=IDLE; all registers in the file = 0; addr=0.
  - data_word_to_send=0, reg_write_valid=0, reg_write_addr=0, reg_write_data=0, status_count=0.
  - Both neg_enable synchronizer flops = 1.
- Chip-select handling:
  - neg_enable passes through a 2-flop synchronizer; cs_active = !synced value.
  - Frame start = synced value falls, i.e. 2 clk after the pin falls.
- States and transitions:
  - IDLE: data_word_to_send = status_count. Frame start -> CMD. word_ready ignored.
  - CMD: on word_ready, take rw = data[WORD_BITS-1] (1=write, 0=read) and addr = data[ADDR_BITS-1:0].
    - If addr >= NUM_REGS -> ERR.
    - Else rw=1 -> WRITE; rw=0 -> READ, and data_word_to_send <= reg[addr] (registered, valid 1 clk after word_ready).
  - WRITE: on word_ready:
    - reg[addr] <= data; reg_write_valid=1 next cycle with that addr/data.
    - status_count++.
    - addr <= (addr==NUM_REGS-1) ? 0 : addr+1.
  - READ: on word_ready, addr advances with the same wrap; data_word_to_send <= reg[next addr] the next cycle.
  - ERR: data_word_to_send = all ones; word_ready ignored; no writes.
  - Any state with cs_active=0 -> IDLE the next cycle, data_word_to_send <= status_count. Any partial state is discarded.
- Latency:
  - reg_write_valid asserts exactly 1 clk after the accepted word_ready, for exactly 1 clk.
  - Register contents update on that same edge.
- Simultaneous events:
  - word_ready in the same cycle cs_active drops is still processed per the current state; the IDLE transition follows.
  - word_ready in the same cycle as frame start is ignored.
- Register file behaviour:
  - Reads in READ reflect all writes from earlier frames.
  - The register file is not readable during a WRITE frame.
- Arithmetic: status_count wraps from 2**WORD_BITS-1 to 0; the address wraps modulo NUM_REGS.
- Reset mid-frame: immediate return to the reset values on the next edge, regardless of neg_enable.

Test Plan:
- Write burst: frame with words 0x83, 0x11, 0x22 -> reg3=0x11, reg4=0x22; two strobes (addr 3/0x11, addr 4/0x22), each 1 clk after word_ready; status_count=2.
- Read burst: after the write burst, frame with 0x03 -> data_word_to_send=0x11 one clk after the command word; after the next word_ready it is 0x22.
- Address wrap: write frame 0x8F, 0xAA, 0xBB -> reg15=0xAA, reg0=0xBB; strobe addresses 15 then 0.
- Frame abort and idle: raise neg_enable after the command only -> no strobe; IDLE shows status_count. word_ready pulses while idle -> no writes.
- Error and reset: NUM_REGS=12, command 0x8D -> data_word_to_send=0xFF, following words write nothing. Assert rst mid-WRITE -> all outputs 0 next cycle.
- Count wrap: 256 write words -> status_count returns to 0.

Source files
------------

// File: rtl/spi_register_bridge.sv
// -----------------------------------------------------------------------------
// spi_register_bridge
//
// Turns the word stream from the SPI secondary shift stage into register
// accesses. Each chip-select frame opens with a command word: the MSB is the
// direction (1 = write, 0 = read) and the low ADDR_BITS bits are the start
// address. The data words that follow form a burst with an auto-incrementing
// address that wraps modulo NUM_REGS. Every written word also appears as a
// one-clock strobe for the downstream motion/stepper configuration logic.
//
// Ports:
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   neg_enable          raw SPI chip-select pin, low = frame active
//   word_ready          one-clock pulse: data_word_received holds a full word
//   data_word_received  word from the SPI secondary, valid with word_ready
//   data_word_to_send   word the SPI secondary shifts out next
//   reg_write_valid     one-clock write strobe
//   reg_write_addr      address of the strobed write
//   reg_write_data      data of the strobed write
//   status_count        data words written since reset, wrapping
// -----------------------------------------------------------------------------
module spi_register_bridge #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int NUM_REGS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 neg_enable,
    input  logic                 word_ready,
    input  logic [WORD_BITS-1:0] data_word_received,
    output logic [WORD_BITS-1:0] data_word_to_send,
    output logic                 reg_write_valid,
    output logic [ADDR_BITS-1:0] reg_write_addr,
    output logic [WORD_BITS-1:0] reg_write_data,
    output logic [WORD_BITS-1:0] status_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_REGS - 1);

    logic [WORD_BITS-1:0] reg_file [NUM_REGS];
    logic [2:0]           state;
    logic [ADDR_BITS-1:0] addr;

    // Two-flop synchronizer for the raw pin, plus one more flop holding the
    // previous synchronized value for falling-edge (frame start) detection.
    logic sync_1;
    logic sync_2;
    logic sync_prev;

    logic                 cs_active;
    logic                 frame_start;
    logic                 cmd_rw;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic                 cmd_addr_bad;
    logic [ADDR_BITS-1:0] next_addr;

    assign cs_active    = !sync_2;
    assign frame_start  = sync_prev && !sync_2;
    assign cmd_rw       = data_word_received[WORD_BITS-1];
    assign cmd_addr     = data_word_received[ADDR_BITS-1:0];
    assign cmd_addr_bad = int'(cmd_addr) >= NUM_REGS;
    assign next_addr    = (addr == LAST_ADDR) ? '0 : addr + ADDR_BITS'(1);

    // NOTE: every flop here uses non-blocking assignment so that all state
    // updates on an edge see the pre-edge values of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            addr              <= '0;
            sync_1            <= 1'b1;
            sync_2            <= 1'b1;
            sync_prev         <= 1'b1;
            data_word_to_send <= '0;
            reg_write_valid   <= 1'b0;
            reg_write_addr    <= '0;
            reg_write_data    <= '0;
            status_count      <= '0;
            // NOTE: the register file is small and must read back as zero
            // after reset, so it is built from resettable flops, not a RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file[i] <= '0;
            end
        end else begin
            sync_1          <= neg_enable;
            sync_2          <= sync_1;
            sync_prev       <= sync_2;
            reg_write_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // word_ready is deliberately ignored here, including in
                    // the frame-start cycle itself.
                    data_word_to_send <= status_count;
                    if (frame_start) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (word_ready) begin
                        addr <= cmd_addr;
                        if (cmd_addr_bad) begin
                            state             <= ERR;
                            data_word_to_send <= '1;
                        end else if (cmd_rw) begin
                            state <= WRITE;
                        end else begin
                            state             <= READ;
                            data_word_to_send <= reg_file[cmd_addr];
                        end
                    end
                end
                WRITE: begin
                    if (word_ready) begin
                        reg_file[addr]  <= data_word_received;
                        reg_write_valid <= 1'b1;
                        reg_write_addr  <= addr;
                        reg_write_data  <= data_word_received;
                        status_count    <= status_count + WORD_BITS'(1);
                        addr            <= next_addr;
                    end
                end
                READ: begin
                    if (word_ready) begin
                        addr              <= next_addr;
                        data_word_to_send <= reg_file[next_addr];
                    end
                end
                ERR: begin
                    data_word_to_send <= '1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Chip-select release wins over the state's own next-state choice,
            // but a word accepted in this same cycle has already been handled
            // above. Any partial burst is dropped.
            if (!cs_active && state != IDLE) begin
                state             <= IDLE;
                data_word_to_send <= status_count;
            end
        end
    end

endmodule

// File: tb/tb_spi_register_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_register_bridge
//
// Directed bench for spi_register_bridge. A main instance uses the default
// 16-register file; a second instance with 12 registers shares the same
// stimulus and is examined only for out-of-range command handling.
// -----------------------------------------------------------------------------
module tb_spi_register_bridge;

    logic       clk;
    logic       rst;
    logic       neg_enable;
    logic       word_ready;
    logic [7:0] data_in;

    logic [7:0] send_16;
    logic       valid_16;
    logic [3:0] waddr_16;
    logic [7:0] wdata_16;
    logic [7:0] count_16;

    logic [7:0] send_12;
    logic       valid_12;
    logic [3:0] waddr_12;
    logic [7:0] wdata_12;
    logic [7:0] count_12;

    int checks = 0;
    int errors = 0;
    int strobes_16 = 0;
    int strobes_12 = 0;

    spi_register_bridge #(.WORD_BITS(8), .ADDR_BITS(4), .NUM_REGS(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .neg_enable         (neg_enable),
        .word_ready         (word_ready),
        .data_word_received (data_in),
        .data_word_to_send  (send_16),
        .reg_write_valid    (valid_16),
        .reg_write_addr     (waddr_16),
        .reg_write_data     (wdata_16),
        .status_count       (count_16)
    );

    spi_register_bridge #(.WORD_BITS(8), .ADDR_BITS(4), .NUM_REGS(12)) dut12 (
        .clk                (clk),
        .rst                (rst),
        .neg_enable         (neg_enable),
        .word_ready         (word_ready),
        .data_word_received (data_in),
        .data_word_to_send  (send_12),
        .reg_write_valid    (valid_12),
        .reg_write_addr     (waddr_12),
        .reg_write_data     (wdata_12),
        .status_count       (count_12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_16) strobes_16++;
        if (valid_12) strobes_12++;
    end

    typedef struct {
        logic       new_frame;
        logic [7:0] word;
        logic       exp_valid;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic       chk_send;
        logic [7:0] exp_send;
        logic [7:0] exp_count;
    } vec_t;

    localparam int NUM_VECS = 12;
    vec_t vecs [NUM_VECS];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the word is sampled on the next edge
    // and the task returns just after that edge.
    task automatic send_word(input logic [7:0] w);
        word_ready = 1'b1;
        data_in    = w;
        tick();
        word_ready = 1'b0;
    endtask

    // Pin low, then three edges: two for the synchronizer, one for IDLE->CMD.
    task automatic start_frame();
        neg_enable = 1'b0;
        repeat (3) tick();
    endtask

    // Pin high, three edges to reach IDLE, one more for IDLE to show the count.
    task automatic end_frame();
        neg_enable = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit in_frame;
        int strobes_before;

        rst        = 1'b1;
        neg_enable = 1'b1;
        word_ready = 1'b0;
        data_in    = 8'h00;
        in_frame   = 1'b0;

        // new_frame, word, valid, addr, data, chk_send, send, count
        vecs[0]  = '{1'b1, 8'h83, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 8'd0};
        vecs[1]  = '{1'b0, 8'h11, 1'b1, 4'h3, 8'h11, 1'b0, 8'h00, 8'd1};
        vecs[2]  = '{1'b0, 8'h22, 1'b1, 4'h4, 8'h22, 1'b0, 8'h00, 8'd2};
        vecs[3]  = '{1'b1, 8'h03, 1'b0, 4'h0, 8'h00, 1'b1, 8'h11, 8'd2};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 8'h22, 8'd2};
        vecs[5]  = '{1'b1, 8'h8F, 1'b0, 4'h0, 8'h00, 1'b1, 8'h02, 8'd2};
        vecs[6]  = '{1'b0, 8'hAA, 1'b1, 4'hF, 8'hAA, 1'b0, 8'h00, 8'd3};
        vecs[7]  = '{1'b0, 8'hBB, 1'b1, 4'h0, 8'hBB, 1'b0, 8'h00, 8'd4};
        vecs[8]  = '{1'b1, 8'h0F, 1'b0, 4'h0, 8'h00, 1'b1, 8'hAA, 8'd4};
        vecs[9]  = '{1'b0, 8'h5A, 1'b0, 4'h0, 8'h00, 1'b1, 8'hBB, 8'd4};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 8'd4};
        vecs[11] = '{1'b1, 8'h04, 1'b0, 4'h0, 8'h00, 1'b1, 8'h22, 8'd4};

        repeat (2) tick();
        rst = 1'b0;
        check("reset send",  32'(send_16),  32'h00);
        check("reset valid", 32'(valid_16), 32'h0);
        check("reset waddr", 32'(waddr_16), 32'h0);
        check("reset wdata", 32'(wdata_16), 32'h00);
        check("reset count", 32'(count_16), 32'h00);

        // Table: write burst, read burst, wrapping write, wrapping read.
        for (int i = 0; i < NUM_VECS; i++) begin
            if (vecs[i].new_frame) begin
                if (in_frame) end_frame();
                start_frame();
                in_frame = 1'b1;
            end
            send_word(vecs[i].word);
            check($sformatf("vec%0d valid", i), 32'(valid_16), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d waddr", i), 32'(waddr_16), 32'(vecs[i].exp_addr));
                check($sformatf("vec%0d wdata", i), 32'(wdata_16), 32'(vecs[i].exp_data));
            end
            if (vecs[i].chk_send)
                check($sformatf("vec%0d send", i), 32'(send_16), 32'(vecs[i].exp_send));
            check($sformatf("vec%0d count", i), 32'(count_16), 32'(vecs[i].exp_count));
        end
        end_frame();
        check("idle shows count", 32'(send_16), 32'd4);

        // Frame aborted right after a write command: nothing is written.
        strobes_before = strobes_16;
        start_frame();
        send_word(8'h85);
        end_frame();
        check("abort strobes", 32'(strobes_16), 32'(strobes_before));
        check("abort count",   32'(count_16),   32'd4);

        // word_ready pulses while idle are ignored.
        for (int i = 0; i < 3; i++) begin
            send_word(8'h55);
            tick();
        end
        check("idle wr strobes", 32'(strobes_16), 32'(strobes_before));
        check("idle wr count",   32'(count_16),   32'd4);
        check("idle wr send",    32'(send_16),    32'd4);

        start_frame();
        send_word(8'h05);
        check("reg5 untouched", 32'(send_16), 32'h00);
        end_frame();

        // A word arriving in the cycle chip-select drops is still written.
        start_frame();
        send_word(8'h86);
        neg_enable = 1'b1;
        repeat (2) tick();
        send_word(8'h77);
        check("late word valid", 32'(valid_16), 32'h1);
        check("late word waddr", 32'(waddr_16), 32'h6);
        check("late word wdata", 32'(wdata_16), 32'h77);
        check("late word count", 32'(count_16), 32'd5);
        tick();
        check("strobe one clk",  32'(valid_16), 32'h0);
        repeat (2) tick();
        check("late idle send",  32'(send_16),  32'd5);
        start_frame();
        send_word(8'h06);
        check("reg6 readback",   32'(send_16),  32'h77);
        end_frame();

        // Out-of-range command on the 12-register instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst12 send",  32'(send_12),  32'h00);
        check("rst16 count", 32'(count_16), 32'h00);
        strobes_before = strobes_12;
        start_frame();
        send_word(8'h8D);
        check("err send",     32'(send_12), 32'hFF);
        send_word(8'h12);
        send_word(8'h34);
        check("err send hold", 32'(send_12),    32'hFF);
        check("err strobes",   32'(strobes_12), 32'(strobes_before));
        check("err count",     32'(count_12),   32'h00);
        check("err waddr",     32'(waddr_12),   32'h0);
        check("err wdata",     32'(wdata_12),   32'h00);

        // Reset while the 16-register instance is mid-WRITE (reg13/14 written).
        check("pre-rst count", 32'(count_16), 32'd2);
        rst        = 1'b1;
        word_ready = 1'b1;
        data_in    = 8'h99;
        tick();
        check("midrst send",  32'(send_16),  32'h00);
        check("midrst valid", 32'(valid_16), 32'h0);
        check("midrst waddr", 32'(waddr_16), 32'h0);
        check("midrst wdata", 32'(wdata_16), 32'h00);
        check("midrst count", 32'(count_16), 32'h00);
        rst        = 1'b0;
        word_ready = 1'b0;
        end_frame();
        start_frame();
        send_word(8'h0D);
        check("reg13 cleared", 32'(send_16), 32'h00);
        send_word(8'h00);
        check("reg14 cleared", 32'(send_16), 32'h00);
        end_frame();

        // 256 written words bring status_count back to zero.
        start_frame();
        send_word(8'h80);
        for (int i = 0; i < 255; i++) begin
            send_word(8'(i));
        end
        check("count 255", 32'(count_16), 32'd255);
        send_word(8'hFE);
        check("count wrap",  32'(count_16), 32'd0);
        check("wrap valid",  32'(valid_16), 32'h1);
        check("wrap waddr",  32'(waddr_16), 32'hF);
        end_frame();
        check("wrap idle send", 32'(send_16), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
